// File: rtl/game_period_ctrl.sv
// rtl/game_period_ctrl.sv - timed play period, generator gating and symbol display (optional PAUSE_EN adds pauseSig)
module game_period_ctrl #(
    parameter int              PERIOD_SECS = 15,
    parameter int              GUARD_SECS  = 1,
    parameter int              NUM_DIGITS  = 4,
    parameter int              SYM_W       = 8,
    parameter int              CNT_W       = 8,
    parameter logic [SYM_W-1:0] BLANK      = {SYM_W{1'b1}}
) (
    input  logic                        Clk100M,
    input  logic                        Rst_n,
    input  logic                        tick1Hz,
    input  logic                        gameSig,
    input  logic                        abortSig,
`ifdef PAUSE_EN
    input  logic                        pauseSig,
`endif
    input  logic                        symValid,
    input  logic                        symSpecial,
    input  logic [SYM_W-1:0]            symData,
    output logic                        genEnable,
    output logic                        startGen,
    output logic                        stopGen,
    output logic                        answerSig,
    output logic                        busy,
    output logic [7:0]                  secsLeft,
    output logic [CNT_W-1:0]            numSpecial,
    output logic [NUM_DIGITS*SYM_W-1:0] gameSegs
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_GUARD  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [7:0] PERIOD_V = 8'(PERIOD_SECS);
    localparam logic [7:0] GUARD_V  = 8'(GUARD_SECS);
    localparam logic [NUM_DIGITS*SYM_W-1:0] ALL_BLANK = {NUM_DIGITS{BLANK}};

    logic [1:0]                  state_q, state_d;
    logic [7:0]                  secs_q, secs_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NUM_DIGITS*SYM_W-1:0] segs_q, segs_d;
    logic                        gen_en_q, gen_en_d;
    logic                        start_q, start_d;
    logic                        stop_q, stop_d;
    logic                        answer_q, answer_d;
    logic                        capture;
    logic                        paused;
    logic                        tick_en;
    logic [7:0]                  secs_dec;

`ifdef PAUSE_EN
    assign paused = pauseSig;
`else
    assign paused = 1'b0;
`endif

    // Ticks are dropped while paused so the count resumes where it froze
    assign tick_en  = tick1Hz & ~paused;
    assign secs_dec = secs_q - 8'd1;

    always_comb begin
        state_d  = state_q;
        secs_d   = secs_q;
        cnt_d    = cnt_q;
        segs_d   = segs_q;
        start_d  = 1'b0;
        stop_d   = 1'b0;
        answer_d = 1'b0;
        capture  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gameSig) begin
                    state_d = S_RUN;
                    start_d = 1'b1;
                    secs_d  = PERIOD_V;
                    cnt_d   = '0;
                    segs_d  = ALL_BLANK;
                end
            end
            S_RUN, S_GUARD: begin
                if (abortSig) begin
                    state_d = S_IDLE;
                    stop_d  = 1'b1;
                    secs_d  = 8'd0;
                end else begin
                    capture = 1'b1;
                    if (tick_en) begin
                        secs_d = secs_dec;
                        if (secs_dec == 8'd0) begin
                            state_d  = S_FINISH;
                            stop_d   = 1'b1;
                            answer_d = 1'b1;
                        end else if (state_q == S_RUN && secs_dec == GUARD_V) begin
                            state_d = S_GUARD;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (capture && symValid) begin
            segs_d[SYM_W-1:0] = symData;
            for (int i = 1; i < NUM_DIGITS; i++)
                segs_d[i*SYM_W +: SYM_W] = segs_q[(i-1)*SYM_W +: SYM_W];
            if (symSpecial)
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign gen_en_d = (state_d == S_RUN) && !paused;

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            secs_q   <= 8'd0;
            cnt_q    <= '0;
            segs_q   <= ALL_BLANK;
            gen_en_q <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            answer_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            secs_q   <= secs_d;
            cnt_q    <= cnt_d;
            segs_q   <= segs_d;
            gen_en_q <= gen_en_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            answer_q <= answer_d;
        end
    end

    assign genEnable  = gen_en_q;
    assign startGen   = start_q;
    assign stopGen    = stop_q;
    assign answerSig  = answer_q;
    assign busy       = (state_q == S_RUN) || (state_q == S_GUARD);
    assign secsLeft   = secs_q;
    assign numSpecial = cnt_q;
    assign gameSegs   = segs_q;
endmodule

// File: tb/tb_game_period_ctrl.sv
// tb/tb_game_period_ctrl.sv - directed vector bench for game_period_ctrl
module tb_game_period_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0, game = 1'b0, abort_s = 1'b0, valid = 1'b0, special = 1'b0;
    logic [7:0]  data = 8'h00;
`ifdef PAUSE_EN
    logic        pause = 1'b0;
`endif
    logic        gen_en, start_g, stop_g, ans, busy;
    logic [7:0]  secs;
    logic [1:0]  cnt;
    logic [31:0] segs;
    int          checks = 0;
    int          errors = 0;
    int          extra_starts;

    always #5 clk = ~clk;

    game_period_ctrl #(
        .PERIOD_SECS(4), .GUARD_SECS(1), .NUM_DIGITS(4), .SYM_W(8), .CNT_W(2)
    ) dut (
        .Clk100M(clk), .Rst_n(rst_n), .tick1Hz(tick), .gameSig(game), .abortSig(abort_s),
`ifdef PAUSE_EN
        .pauseSig(pause),
`endif
        .symValid(valid), .symSpecial(special), .symData(data),
        .genEnable(gen_en), .startGen(start_g), .stopGen(stop_g), .answerSig(ans),
        .busy(busy), .secsLeft(secs), .numSpecial(cnt), .gameSegs(segs)
    );

    typedef struct {
        logic       tick, game, abrt, valid, special;
        logic [7:0] data;
        logic       start, gen, stop, ans, busy;
        logic [7:0] secs;
        logic [1:0] cnt;
        logic [31:0] segs;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(logic t, logic g, logic a, logic v, logic s, logic [7:0] d,
                                logic es, logic eg, logic ep, logic ea, logic eb,
                                logic [7:0] esec, logic [1:0] ec, logic [31:0] eseg);
        vec_t r;
        r.tick = t; r.game = g; r.abrt = a; r.valid = v; r.special = s; r.data = d;
        r.start = es; r.gen = eg; r.stop = ep; r.ans = ea; r.busy = eb;
        r.secs = esec; r.cnt = ec; r.segs = eseg;
        return r;
    endfunction

    function automatic logic [46:0] outs();
        return {start_g, gen_en, stop_g, ans, busy, secs, cnt, segs};
    endfunction

    task automatic check(input string name, input logic [46:0] got, input logic [46:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic t, input logic g, input logic a, input logic v,
                          input logic s, input logic [7:0] d);
        tick = t; game = g; abort_s = a; valid = v; special = s; data = d;
    endtask

    initial begin
        //            tk g ab v sp data    st gn sp an bz secs cnt segs
        vecs[0]  = mk(0, 1, 0, 0, 0, 8'h00, 1, 1, 0, 0, 1, 8'd4, 2'd0, 32'hFFFFFFFF);
        vecs[1]  = mk(0, 0, 0, 1, 0, 8'h11, 0, 1, 0, 0, 1, 8'd4, 2'd0, 32'hFFFFFF11);
        vecs[2]  = mk(0, 0, 0, 1, 1, 8'h22, 0, 1, 0, 0, 1, 8'd4, 2'd1, 32'hFFFF1122);
        vecs[3]  = mk(1, 0, 0, 1, 0, 8'h33, 0, 1, 0, 0, 1, 8'd3, 2'd1, 32'hFF112233);
        vecs[4]  = mk(0, 0, 0, 1, 0, 8'h44, 0, 1, 0, 0, 1, 8'd3, 2'd1, 32'h11223344);
        vecs[5]  = mk(1, 0, 0, 1, 1, 8'h55, 0, 1, 0, 0, 1, 8'd2, 2'd2, 32'h22334455);
        vecs[6]  = mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'd1, 2'd2, 32'h22334455);
        vecs[7]  = mk(0, 0, 0, 1, 1, 8'h66, 0, 0, 0, 0, 1, 8'd1, 2'd3, 32'h33445566);
        vecs[8]  = mk(1, 0, 0, 1, 1, 8'h77, 0, 0, 1, 1, 0, 8'd0, 2'd0, 32'h44556677);
        vecs[9]  = mk(0, 1, 0, 1, 1, 8'h88, 0, 0, 0, 0, 0, 8'd0, 2'd0, 32'h44556677);
        vecs[10] = mk(1, 0, 0, 1, 1, 8'h99, 0, 0, 0, 0, 0, 8'd0, 2'd0, 32'h44556677);
        vecs[11] = mk(0, 1, 0, 0, 0, 8'h00, 1, 1, 0, 0, 1, 8'd4, 2'd0, 32'hFFFFFFFF);
        vecs[12] = mk(1, 0, 0, 1, 1, 8'h01, 0, 1, 0, 0, 1, 8'd3, 2'd1, 32'hFFFFFF01);
        vecs[13] = mk(1, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 8'd2, 2'd1, 32'hFFFFFF01);
        vecs[14] = mk(1, 0, 1, 1, 1, 8'h02, 0, 0, 1, 0, 0, 8'd0, 2'd1, 32'hFFFFFF01);
        vecs[15] = mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'd0, 2'd1, 32'hFFFFFF01);
        vecs[16] = mk(0, 1, 0, 0, 0, 8'h00, 1, 1, 0, 0, 1, 8'd4, 2'd0, 32'hFFFFFFFF);
        vecs[17] = mk(0, 0, 0, 1, 1, 8'hA1, 0, 1, 0, 0, 1, 8'd4, 2'd1, 32'hFFFFFFA1);
        vecs[18] = mk(0, 0, 0, 1, 1, 8'hA2, 0, 1, 0, 0, 1, 8'd4, 2'd2, 32'hFFFFA1A2);
        vecs[19] = mk(0, 0, 0, 1, 1, 8'hA3, 0, 1, 0, 0, 1, 8'd4, 2'd3, 32'hFFA1A2A3);
        vecs[20] = mk(0, 0, 0, 1, 1, 8'hA4, 0, 1, 0, 0, 1, 8'd4, 2'd0, 32'hA1A2A3A4);
        vecs[21] = mk(0, 0, 0, 1, 1, 8'hA5, 0, 1, 0, 0, 1, 8'd4, 2'd1, 32'hA2A3A4A5);
        vecs[22] = mk(0, 0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'd0, 2'd1, 32'hA2A3A4A5);
        vecs[23] = mk(0, 0, 0, 1, 1, 8'hB0, 0, 0, 0, 0, 0, 8'd0, 2'd1, 32'hA2A3A4A5);

        #12;
        check("reset_state", outs(), {5'b0, 8'd0, 2'd0, 32'hFFFFFFFF});
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < 24; i++) begin
            set_in(vecs[i].tick, vecs[i].game, vecs[i].abrt, vecs[i].valid,
                   vecs[i].special, vecs[i].data);
            step();
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].start, vecs[i].gen, vecs[i].stop, vecs[i].ans, vecs[i].busy,
                   vecs[i].secs, vecs[i].cnt, vecs[i].segs});
        end

        // gameSig held high for a whole period: only one start until back in IDLE
        set_in(0, 1, 0, 0, 0, 8'h00);
        step();
        check("held_start", {39'd0, start_g, busy, secs}, {39'd0, 1'b1, 1'b1, 8'd4});
        extra_starts = 0;
        for (int t = 0; t < 4; t++) begin
            tick = 1'b0;
            step();
            extra_starts += int'(start_g);
            tick = 1'b1;
            step();
            extra_starts += int'(start_g);
        end
        tick = 1'b0;
        check("held_finish", {44'd0, stop_g, ans, busy}, {44'd0, 1'b1, 1'b1, 1'b0});
        check("held_no_restart", 47'(extra_starts), 47'd0);
        step();
        check("held_idle", {45'd0, start_g, busy}, {45'd0, 1'b0, 1'b0});
        step();
        check("held_restart", outs(), {5'b11001, 8'd4, 2'd0, 32'hFFFFFFFF});

        // asynchronous reset in the middle of RUN
        set_in(1, 0, 0, 1, 1, 8'h5A);
        step();
        check("pre_reset_run", {37'd0, busy, secs, cnt}, {37'd0, 1'b1, 8'd3, 2'd1});
        set_in(0, 0, 0, 0, 0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), {5'b0, 8'd0, 2'd0, 32'hFFFFFFFF});
        @(negedge clk);
        rst_n = 1'b1;
        #1;

`ifdef PAUSE_EN
        set_in(0, 1, 0, 0, 0, 8'h00);
        step();
        game = 1'b0;
        pause = 1'b1;
        step();
        for (int t = 0; t < 3; t++) begin
            tick = 1'b1;
            valid = (t == 0);
            special = 1'b1;
            data = 8'hC3;
            step();
            tick = 1'b0;
            valid = 1'b0;
            step();
        end
        check("pause_frozen", {38'd0, gen_en, secs}, {38'd0, 1'b0, 8'd4});
        check("pause_drain", {13'd0, cnt, segs}, {13'd0, 2'd1, 32'hFFFFFFC3});
        pause = 1'b0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("pause_resume", {38'd0, gen_en, secs}, {38'd0, 1'b1, 8'd3});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/game_period_ctrl.md
Name: game_period_ctrl

Overview:
Parametrised game-period controller for the symbol-counting game. It runs in the single Clk100M domain and takes a one-cycle 1 Hz tick enable instead of a second clock. It times a configurable play period, gates the symbol generator, and keeps a NUM_DIGITS-deep shift display of generated symbols plus a special-symbol count. At period end it raises answerSig to hand off to the answer phase.

Parameters:
PERIOD_SECS, 15, total play period in seconds (2..255)
GUARD_SECS, 1, trailing seconds with generation disabled before answer (0..PERIOD_SECS-1)
NUM_DIGITS, 4, number of displayed symbol slots (1..8)
SYM_W, 8, width of one segment pattern
CNT_W, 8, width of special counter
BLANK, {SYM_W{1'b1}}, segment pattern for a blank digit

Ports:
Clk100M  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
tick1Hz  in  1  one-Clk100M-cycle pulse once per second
gameSig  in  1  start request (level or pulse, sampled per cycle)
abortSig  in  1  abandon the current period
symValid  in  1  generator produced a symbol this cycle
symSpecial  in  1  qualifies symValid: symbol is special
symData  in  SYM_W  segment pattern of the new symbol
genEnable  out  1  enables the symbol generator
startGen  out  1  one-cycle pulse at period start
stopGen  out  1  one-cycle pulse at period end or abort
answerSig  out  1  one-cycle pulse at normal period end only
busy  out  1  high in RUN or GUARD
secsLeft  out  8  seconds remaining in the period
numSpecial  out  CNT_W  special symbols seen this period
gameSegs  out  NUM_DIGITS*SYM_W  slot 0 in the LSBs (newest), slot N-1 in the MSBs (oldest)

Behaviour:
- Reset (async, Rst_n=0): state IDLE. genEnable, startGen, stopGen, answerSig and busy are 0. secsLeft=0, numSpecial=0, all slots BLANK.
- FSM states: IDLE, RUN, GUARD, FINISH.
- IDLE: when gameSig=1, go to RUN next cycle.
  - Same edge: startGen=1 for one cycle, secsLeft=PERIOD_SECS, numSpecial=0, all slots BLANK.
- RUN: genEnable=1 and busy=1. Each tick1Hz decrements secsLeft.
  - If the decremented value equals GUARD_SECS, go to GUARD.
  - If GUARD_SECS=0 and the decremented value is 0, go to FINISH directly.
- GUARD: genEnable=0, busy=1. Each tick decrements secsLeft; on reaching 0, go to FINISH.
- FINISH: lasts exactly one cycle. stopGen=1 and answerSig=1 in that cycle, then IDLE.
  - secsLeft holds 0; numSpecial and gameSegs hold their final values until the next start.
- Registered outputs: genEnable, startGen, stopGen and answerSig are registered. Their latency is 1 cycle from the causing tick or gameSig edge.
- Symbol capture is accepted in RUN and GUARD only. On symValid=1:
  - Slots shift toward the oldest position; slot 0 takes symData.
  - numSpecial increments if symSpecial=1.
  - symValid in IDLE or FINISH is ignored, which absorbs generator pipeline latency from before enable and after disable.
- numSpecial wraps modulo 2^CNT_W.
- gameSig while busy is ignored (no restart).
- abortSig while busy: go to IDLE next cycle.
  - stopGen=1 for one cycle, answerSig stays 0, genEnable=0, secsLeft=0.
  - Display and count are retained.
  - abortSig has priority over a same-cycle tick and over symValid.
- Same cycle tick1Hz and symValid: both take effect; the symbol is counted even on the cycle that enters GUARD or FINISH.
- Same cycle gameSig and FINISH: the start is ignored; it needs gameSig to still be high in IDLE.
- tick1Hz in IDLE or FINISH has no effect.

Optional Feature:
PAUSE_EN: adds input pauseSig (1 bit).
- While pauseSig=1 in RUN or GUARD: ticks are ignored, secsLeft freezes and genEnable is forced to 0.
- symValid is still accepted, to drain in-flight symbols.
- On release, timing resumes from the frozen count.
- abortSig still works while paused.
Without PAUSE_EN the port does not exist and timing is never frozen.

Test Plan:
- PERIOD_SECS=4, GUARD_SECS=1: pulse gameSig, then 4 ticks -> startGen one cycle; genEnable high for ticks 1-3; GUARD after tick 3 (secsLeft=1); after tick 4, stopGen and answerSig one cycle each; secsLeft=0.
- During RUN inject symbols 0x11, 0x22(special), 0x33, 0x44, 0x55(special) with NUM_DIGITS=4 -> gameSegs=0x22334455, numSpecial=2.
- abortSig with secsLeft=2 concurrent with tick1Hz -> stopGen=1, answerSig=0, IDLE, secsLeft=0, display retained.
- gameSig held high through the whole period -> no restart while busy; new startGen the cycle after returning to IDLE with slots BLANK and numSpecial=0.
- CNT_W=2: five special symbols -> numSpecial=1 (wrap); symValid in IDLE -> no change.
- Assert Rst_n=0 mid-RUN -> all outputs at reset values immediately (asynchronous), slots BLANK; PAUSE_EN build: pause 3 ticks mid-RUN -> secsLeft unchanged, genEnable=0.
